axi_ram_slave: RTL and testbench



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_burst_addr.sv | 29 ++
 rtl/axi_ram_slave.sv | 195 +++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, channel widths and engine state types used by the
// RAM responder and the crossbar.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA} r_state_t;

  function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; reserved bursts
// and WRAP with an illegal length step like INCR.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic [SIZE_W-1:0]  size,
  input  logic [LEN_W-1:0]   len,
  input  logic [BURST_W-1:0] burst,
  output logic [ADDR_W-1:0]  next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    bytes     = ADDR_W'(1) << size;
    wrap_mask = (ADDR_W'(len) + ADDR_W'(1)) * bytes - ADDR_W'(1);
    next_addr = (addr & ~(bytes - ADDR_W'(1))) + bytes;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_len_ok(len)) begin
      next_addr = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave fronting a register-array RAM with independent write and read engines.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting beats until WLAST
// W_RESP | BVALID high until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, one beat per RREADY cycle until RLAST
module axi_ram_slave
  import axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_DEPTH_LOG2 = 10
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [LEN_W-1:0]            S_AXI_AWLEN,
  input  logic [SIZE_W-1:0]           S_AXI_AWSIZE,
  input  logic [BURST_W-1:0]          S_AXI_AWBURST,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [RESP_W-1:0]           S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [LEN_W-1:0]            S_AXI_ARLEN,
  input  logic [SIZE_W-1:0]           S_AXI_ARSIZE,
  input  logic [BURST_W-1:0]          S_AXI_ARBURST,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [RESP_W-1:0]           S_AXI_RRESP,
  output logic                        S_AXI_RLAST,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY
);

  localparam int NB    = AXI_DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int WI_HI = MEM_DEPTH_LOG2 + LSB - 1;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

  w_state_t                w_state, w_state_nxt;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  logic [AXI_ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
  logic [LEN_W-1:0]          w_len;
  logic [SIZE_W-1:0]         w_size;
  logic [BURST_W-1:0]        w_burst;
  logic [LEN_W:0]            w_beat;
  logic                      aw_hs, w_hs, b_hs, w_in_len;

  r_state_t                r_state, r_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
  logic [LEN_W-1:0]          r_len;
  logic [SIZE_W-1:0]         r_size;
  logic [BURST_W-1:0]        r_burst;
  logic [LEN_W-1:0]          r_beat;
  logic                      ar_hs, r_hs;

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
  // Beat counter saturates past LEN so overrun beats are dropped, not aliased.
  assign w_in_len = (w_beat <= {1'b0, w_len});

  axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH)) u_w_addr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nxt)
  );

  axi_burst_addr #(.ADDR_W(AXI_ADDR_WIDTH)) u_r_addr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nxt)
  );

  always_comb begin
    w_state_nxt = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && S_AXI_WLAST) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they stay low in reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= RESP_OKAY;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_size        <= '0;
      w_burst       <= '0;
      w_beat        <= '0;
    end else begin
      w_state       <= w_state_nxt;
      S_AXI_AWREADY <= (w_state_nxt == W_IDLE);
      S_AXI_WREADY  <= (w_state_nxt == W_DATA);
      S_AXI_BVALID  <= (w_state_nxt == W_RESP);
      if (aw_hs) begin
        w_id    <= S_AXI_AWID;
        w_addr  <= S_AXI_AWADDR;
        w_len   <= S_AXI_AWLEN;
        w_size  <= S_AXI_AWSIZE;
        w_burst <= S_AXI_AWBURST;
        w_beat  <= '0;
      end
      if (w_hs) begin
        w_addr <= w_addr_nxt;
        if (!w_beat[LEN_W]) w_beat <= w_beat + 1'b1;
        if (S_AXI_WLAST) begin
          S_AXI_BID   <= w_id;
          S_AXI_BRESP <= ((w_beat != {1'b0, w_len}) || (w_burst == BURST_RSVD)) ?
                         RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && w_in_len) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b]) mem[w_addr[WI_HI:LSB]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs && S_AXI_RLAST) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // RDATA is prefetched one beat ahead so beats can stream back-to-back.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_beat        <= '0;
    end else begin
      r_state       <= r_state_nxt;
      S_AXI_ARREADY <= (r_state_nxt == R_IDLE);
      S_AXI_RVALID  <= (r_state_nxt == R_DATA);
      if (ar_hs) begin
        r_addr      <= S_AXI_ARADDR;
        r_len       <= S_AXI_ARLEN;
        r_size      <= S_AXI_ARSIZE;
        r_burst     <= S_AXI_ARBURST;
        r_beat      <= '0;
        S_AXI_RID   <= S_AXI_ARID;
        S_AXI_RDATA <= mem[S_AXI_ARADDR[WI_HI:LSB]];
        S_AXI_RLAST <= (S_AXI_ARLEN == '0);
        S_AXI_RRESP <= (S_AXI_ARBURST == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
      end else if (r_hs && !S_AXI_RLAST) begin
        r_addr      <= r_addr_nxt;
        r_beat      <= r_beat + 8'd1;
        S_AXI_RDATA <= mem[r_addr_nxt[WI_HI:LSB]];
        S_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave: byte-level memory model plus burst address
// arithmetic, with one negedge monitor checking every B and R cycle.
module tb_axi_ram_slave;
  import axi_pkg::*;

  localparam int ID_W = 2;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int DL   = 10;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  always #5 ACLK = ~ACLK;

  axi_ram_slave #(
    .AXI_ID_WIDTH(ID_W), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .MEM_DEPTH_LOG2(DL)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
    .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
    .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } rbeat_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } bexp_t;

  rbeat_t      rexp[$];
  bexp_t       bexp[$];
  logic [31:0] rcap[$];
  logic [1:0]  rrcap[$];
  logic [1:0]  bcap;
  logic [7:0]  mm [4096];
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  int          checks = 0;
  int          passes = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                            input int size, input logic [1:0] burst, input int i);
    longint unsigned bytes, total, base, la;
    bytes = longint'(1) << size;
    la    = longint'(a);
    if (burst == BURST_FIXED) return a;
    if (burst == BURST_WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      total = longint'(len + 1) * bytes;
      base  = (la / total) * total;
      return 32'(base + ((la - base) + longint'(i) * bytes) % total);
    end
    if (i == 0) return a;
    return 32'((la / bytes) * bytes + longint'(i) * bytes);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd1023);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int w;
    w = widx(a);
    return {mm[w*4+3], mm[w*4+2], mm[w*4+1], mm[w*4]};
  endfunction

  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (bvalid) begin
        if (bexp.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          chk("bid", 64'(bid), 64'(bexp[0].id));
          chk("bresp", 64'(bresp), 64'(bexp[0].resp));
          if (bready) begin
            bcap = bresp;
            void'(bexp.pop_front());
          end
        end
      end
      if (rvalid) begin
        if (rexp.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          chk("rid", 64'(rid), 64'(rexp[0].id));
          chk("rdata", 64'(rdata), 64'(rexp[0].data));
          chk("rresp", 64'(rresp), 64'(rexp[0].resp));
          chk("rlast", 64'(rlast), 64'(rexp[0].last));
          if (rready) begin
            rcap.push_back(rdata);
            rrcap.push_back(rresp);
            void'(rexp.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                          input int size, input logic [1:0] burst, input int nbeats);
    int n;
    logic [31:0] ba;
    for (int b = 0; b < nbeats; b++) begin
      if (b <= len) begin
        ba = beat_addr(a, len, size, burst, b);
        for (int k = 0; k < 4; k++) if (wstb[b][k]) mm[widx(ba)*4+k] = wdat[b][k*8 +: 8];
      end
    end
    bexp.push_back({id, (nbeats != len + 1 || burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY});
    bcap = 2'b11;
    awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = burst; awvalid = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!awready && n < 100) begin @(negedge ACLK); n++; end
    chk("aw_handshake", 64'(awready), 64'd1);
    @(posedge ACLK); #1;
    awvalid = 1'b0;
    chk("wready_after_aw", 64'(wready), 64'd1);
    for (int b = 0; b < nbeats; b++) begin
      wdata = wdat[b]; wstrb = wstb[b]; wlast = (b == nbeats - 1); wvalid = 1'b1;
      @(negedge ACLK);
      n = 0;
      while (!wready && n < 100) begin @(negedge ACLK); n++; end
      chk("w_handshake", 64'(wready), 64'd1);
      @(posedge ACLK); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_after_wlast", 64'(bvalid), 64'd1);
    chk("wready_drop", 64'(wready), 64'd0);
    bready = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!bvalid && n < 100) begin @(negedge ACLK); n++; end
    chk("b_handshake", 64'(bvalid), 64'd1);
    @(posedge ACLK); #1;
    bready = 1'b0;
    chk("awready_after_b", 64'(awready), 64'd1);
  endtask

  task automatic push_rexp(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                           input int size, input logic [1:0] burst);
    rbeat_t e;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.data = model_word(beat_addr(a, len, size, burst, i));
      e.resp = (burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
      e.last = (i == len);
      rexp.push_back(e);
    end
  endtask

  task automatic ar_phase(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                          input int size, input logic [1:0] burst);
    int n;
    arid = id; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = burst; arvalid = 1'b1;
    @(negedge ACLK);
    n = 0;
    while (!arready && n < 100) begin @(negedge ACLK); n++; end
    chk("ar_handshake", 64'(arready), 64'd1);
    @(posedge ACLK); #1;
    arvalid = 1'b0;
    chk("rvalid_after_ar", 64'(rvalid), 64'd1);
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] a, input int len,
                         input int size, input logic [1:0] burst, input bit toggle);
    int k;
    push_rexp(id, a, len, size, burst);
    rcap.delete();
    rrcap.delete();
    ar_phase(id, a, len, size, burst);
    k = 0;
    while (rcap.size() < len + 1 && k < 200) begin
      rready = toggle ? (k % 2 == 0) : 1'b1;
      @(posedge ACLK); #1;
      k++;
    end
    rready = 1'b0;
    chk("r_beat_count", 64'(rcap.size()), 64'(len + 1));
    chk("arready_after_last", 64'(arready), 64'd1);
  endtask

  initial begin
    ARESETN = 1'b0;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_readies", 64'({awready, wready, bvalid, arready, rvalid, rlast}), 64'd0);
    chk("reset_payload", 64'({bid, bresp, rid, rresp}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("awready_out_of_reset", 64'(awready), 64'd1);

    // single write then read
    wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
    do_write(2'd1, 32'h10, 0, 2, BURST_INCR, 1);
    chk("single_bresp", 64'(bcap), 64'd0);
    do_read(2'd2, 32'h10, 0, 2, BURST_INCR, 1'b0);
    chk("single_rdata", 64'(rcap[0]), 64'hDEADBEEF);

    // INCR burst, read back with RREADY toggling
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(2'd3, 32'h100, 3, 2, BURST_INCR, 4);
    do_read(2'd0, 32'h100, 3, 2, BURST_INCR, 1'b1);
    for (int i = 0; i < 4; i++) chk("incr_rdata", 64'(rcap[i]), 64'(i + 1));

    // WRAP write at 0x08 lands 1,2,3,4 at 0x08,0x0C,0x00,0x04
    do_write(2'd1, 32'h08, 3, 2, BURST_WRAP, 4);
    do_read(2'd1, 32'h00, 3, 2, BURST_INCR, 1'b0);
    chk("wrap_rd0", 64'(rcap[0]), 64'd3);
    chk("wrap_rd1", 64'(rcap[1]), 64'd4);
    chk("wrap_rd2", 64'(rcap[2]), 64'd1);
    chk("wrap_rd3", 64'(rcap[3]), 64'd2);

    // byte strobes
    wdat[0] = 32'h11223344; wstb[0] = 4'hF;
    do_write(2'd0, 32'h40, 0, 2, BURST_INCR, 1);
    wdat[0] = 32'hAABBCCDD; wstb[0] = 4'b0101;
    do_write(2'd0, 32'h40, 0, 2, BURST_INCR, 1);
    do_read(2'd0, 32'h40, 0, 2, BURST_INCR, 1'b0);
    chk("strobe_merge", 64'(rcap[0]), 64'h11BB33DD);

    // FIXED burst keeps the last beat
    wdat[0] = 32'hA; wdat[1] = 32'hB; wdat[2] = 32'hC;
    for (int i = 0; i < 3; i++) wstb[i] = 4'hF;
    do_write(2'd2, 32'h20, 2, 2, BURST_FIXED, 3);
    do_read(2'd2, 32'h20, 0, 2, BURST_FIXED, 1'b0);
    chk("fixed_last_beat", 64'(rcap[0]), 64'hC);

    // early WLAST -> SLVERR
    wdat[0] = 32'h55; wdat[1] = 32'h66; wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(2'd3, 32'h200, 3, 2, BURST_INCR, 2);
    chk("early_wlast_bresp", 64'(bcap), 64'd2);

    // beats past LEN are dropped
    wdat[0] = 32'h77;
    do_write(2'd0, 32'h54, 0, 2, BURST_INCR, 1);
    wdat[0] = 32'h9; wdat[1] = 32'h10;
    do_write(2'd0, 32'h50, 0, 2, BURST_INCR, 2);
    chk("late_wlast_bresp", 64'(bcap), 64'd2);
    do_read(2'd0, 32'h50, 1, 2, BURST_INCR, 1'b0);
    chk("overrun_beat0", 64'(rcap[0]), 64'h9);
    chk("overrun_not_written", 64'(rcap[1]), 64'h77);

    // reserved read burst -> SLVERR on every beat
    do_read(2'd1, 32'h100, 1, 2, BURST_RSVD, 1'b0);
    chk("rsvd_rresp0", 64'(rrcap[0]), 64'd2);
    chk("rsvd_rresp1", 64'(rrcap[1]), 64'd2);

    // overlapping write and read bursts
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 5); wstb[i] = 4'hF; end
    fork
      do_write(2'd3, 32'h300, 3, 2, BURST_INCR, 4);
      do_read(2'd2, 32'h100, 3, 2, BURST_INCR, 1'b0);
    join
    for (int i = 0; i < 4; i++) chk("concurrent_rd", 64'(rcap[i]), 64'(i + 1));
    do_read(2'd2, 32'h300, 3, 2, BURST_INCR, 1'b0);
    for (int i = 0; i < 4; i++) chk("concurrent_wr", 64'(rcap[i]), 64'(i + 5));

    // reset mid-read-burst
    push_rexp(2'd1, 32'h100, 3, 2, BURST_INCR);
    ar_phase(2'd1, 32'h100, 3, 2, BURST_INCR);
    rready = 1'b0;
    repeat (2) @(posedge ACLK);
    #2;
    ARESETN = 1'b0;
    rexp.delete();
    #1;
    chk("rvalid_async_drop", 64'(rvalid), 64'd0);
    chk("arready_in_reset", 64'(arready), 64'd0);
    chk("rlast_in_reset", 64'(rlast), 64'd0);
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    #1;
    chk("arready_at_release", 64'(arready), 64'd0);
    repeat (2) @(posedge ACLK);
    #1;
    chk("arready_after_release", 64'(arready), 64'd1);
    chk("rvalid_after_release", 64'(rvalid), 64'd0);
    do_read(2'd1, 32'h100, 3, 2, BURST_INCR, 1'b0);
    for (int i = 0; i < 4; i++) chk("mem_kept_over_reset", 64'(rcap[i]), 64'(i + 1));

    repeat (3) @(posedge ACLK);
    chk("b_queue_drained", 64'(bexp.size()), 64'd0);
    chk("r_queue_drained", 64'(rexp.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
